csa_booth_mul_ctrl: RTL and testbench

Sequential signed multiplier controller for the MiniSRC MUL instruction. It sequences the 3:2 carry-save reduction datapath using radix-4 Booth recoding. One Booth partial product is folded into a redundant sum/carry pair per cycle. A final carry-propagate add resolves the pair into the 64-bit HI/LO result. It sits between the control unit (start/busy/done handshake) and the HI/LO registers.

---
 rtl/csa_booth_mul_ctrl_if.sv | 23 ++
 rtl/csa_booth_mul_ctrl.sv | 132 +++++++++++++
 tb/tb_csa_booth_mul_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/csa_booth_mul_ctrl_if.sv
// Start/busy/done handshake and operand/result bus between the
// control unit (master) and the Booth carry-save multiplier (slave).
interface csa_booth_mul_ctrl_if #(
    parameter int W = 32
);
    logic         start;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/csa_booth_mul_ctrl.sv
// Sequential signed radix-4 Booth multiplier: one partial product per
// cycle folded into a carry-save pair, then one carry-propagate add.
module csa_booth_mul_ctrl #(
    parameter int W = 32
) (
    input logic                 clk,
    input logic                 clr,
    csa_booth_mul_ctrl_if.slave bus
);
    localparam int STEPS = W / 2;
    localparam int W2    = 2 * W;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    logic [W2-1:0] sum_q, sum_d;
    logic [W2-1:0] carry_q, carry_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          done_q, done_d;

    logic [W:0]    y_ext;
    logic [2:0]    trip;
    logic [W2-1:0] xs;
    logic [W2-1:0] mag;
    logic [W2-1:0] shifted;
    logic [W2-1:0] pp;
    logic [W2-1:0] sum_n;
    logic [W2-1:0] carry_n;
    logic          neg;

    // Y[-1] = 0 is the appended LSB, so bit 2i of y_ext is Y[2i-1].
    assign y_ext = {y_q, 1'b0};
    assign trip  = 3'(y_ext >> (2 * cnt_q));
    assign xs    = {{W{x_q[W-1]}}, x_q};

    always_comb begin
        mag = '0;
        neg = 1'b0;
        unique case (trip)
            3'b001, 3'b010: mag = xs;
            3'b011:         mag = xs << 1;
            3'b100: begin
                mag = xs << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = xs;
                neg = 1'b1;
            end
            default:        mag = '0;
        endcase
    end

    // Complement after shifting so the +1 always lands on bit 0.
    assign shifted = mag << (2 * cnt_q);
    assign pp      = neg ? ~shifted : shifted;
    assign sum_n   = sum_q ^ carry_q ^ pp;
    assign carry_n = (((sum_q & carry_q) | (sum_q & pp) | (carry_q & pp)) << 1)
                   | W2'(neg);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                x_d     = bus.multiplicand;
                y_d     = bus.multiplier;
                sum_d   = '0;
                carry_d = '0;
                cnt_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                sum_d   = sum_n;
                carry_d = carry_n;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) state_d = RESOLVE;
            end
            RESOLVE: begin
                {hi_d, lo_d} = sum_q + carry_q;
                done_d       = 1'b1;
                state_d      = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_csa_booth_mul_ctrl.sv
// Scoreboard bench: driver queues exact signed products, monitor pops
// and compares on every done pulse.
module tb_csa_booth_mul_ctrl;
    logic clk;
    logic clr;
    int   checks;
    int   failures;
    int   n_issued;
    int   n_done;
    logic [63:0] exp_q[$];

    csa_booth_mul_ctrl_if #(.W(32)) bus ();

    csa_booth_mul_ctrl #(.W(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] x,
                                          input logic [31:0] y);
        longint a;
        longint b;
        a = longint'(signed'(x));
        b = longint'(signed'(y));
        return a * b;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!clr && bus.done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("product", {bus.hi, bus.lo}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int g;
        g = 0;
        while (bus.busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (bus.busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = x;
        bus.multiplier   = y;
        exp_q.push_back(model(x, y));
        n_issued++;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
    endtask

    // Called #1 after the start edge; runs until busy drops.
    task automatic track(output int lat, output int bcnt, output bit got);
        lat  = 0;
        bcnt = 0;
        got  = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (bus.busy) bcnt++;
            if (bus.done && !got) begin
                got = 1'b1;
                lat = k;
            end
            if (!bus.busy) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                         input bit chk_lat);
        int lat;
        int bcnt;
        bit got;
        wait_idle();
        issue(x, y);
        track(lat, bcnt, got);
        check("done_seen", 64'(got), 64'd1);
        if (chk_lat) begin
            check("latency", 64'(lat), 64'd17);
            check("busy_cycles", 64'(bcnt), 64'd18);
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        bit got;
        checks   = 0;
        failures = 0;
        n_issued = 0;
        n_done   = 0;
        clr              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        clr = 1'b0;

        do_op(32'd3, 32'd5, 1'b1);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
        do_op(32'h80000000, 32'h80000000, 1'b0);
        do_op(32'h80000000, 32'h7FFFFFFF, 1'b0);
        do_op(32'd0, 32'h12345678, 1'b0);

        // Busy lockout: restarts at cycle 5 and on the DONE cycle.
        wait_idle();
        issue(32'd6, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 32'd9;
        bus.multiplier   = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            #1;
            got = bus.done;
        end
        check("lockout_done_seen", 64'(got), 64'd1);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("lockout_busy", 64'(bus.busy), 64'd0);
        check("lockout_hold", {bus.hi, bus.lo}, 64'd42);
        bus.start = 1'b0;
        repeat (25) @(posedge clk);
        check("lockout_n_done", 64'(n_done), 64'(n_issued));
        do_op(32'd9, 32'd9, 1'b1);

        // Abort mid-operation after a prior result of 42.
        do_op(32'd6, 32'd7, 1'b0);
        issue(32'd100, 32'd200);
        repeat (7) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        void'(exp_q.pop_back());
        n_issued--;
        @(negedge clk);
        clr = 1'b0;
        do_op(32'd100, 32'd200, 1'b1);

        for (int i = 0; i < 256; i++) begin
            wait_idle();
            issue($urandom, $urandom);
            track(lat, bcnt, got);
            check("rand_done_seen", 64'(got), 64'd1);
        end

        repeat (5) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
